branch_predictor: RTL and testbench

- Fetch-side counterpart of the EX-stage branch resolution unit.
- In IF, it predicts the next PC for the current fetch PC using a direct-mapped table: 2-bit saturating counters plus a branch target buffer (BTB).
- In EX, it takes each resolved branch/jump outcome, trains the table, and raises a one-cycle mispredict redirect that the pipeline uses to flush IF/ID.

---
 rtl/branch_predictor_pkg.sv | 17 +
 rtl/branch_predictor_sat_counter.sv | 29 ++
 rtl/branch_predictor.sv | 125 ++++++++++++
 tb/tb_branch_predictor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// The 2-bit counter encoding lives here so the table, the counter
// next-state logic and any future users agree on what each value means.
package branch_predictor_pkg;

  // Default number of direct-mapped table entries.
  localparam int BP_ENTRIES = 16;

  // 2-bit saturating counter states; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    BP_CTR_SNT = 2'b00,
    BP_CTR_WNT = 2'b01,
    BP_CTR_WT  = 2'b10,
    BP_CTR_ST  = 2'b11
  } bpCtr_e;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Next-state function for one 2-bit saturating prediction counter.
// Unconditional jumps force the counter straight to strongly-taken.
// Conditional branches otherwise move one step toward the actual outcome.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bpCtr_e ctr_i,
  input  logic   taken_i,
  input  logic   forceSt_i,
  output bpCtr_e ctrNext_o
);

  // Saturating step: clamp at strongly-taken and strongly-not-taken.
  always_comb begin
    ctrNext_o = ctr_i;
    if (forceSt_i) begin
      ctrNext_o = BP_CTR_ST;
    end else if (taken_i) begin
      if (ctr_i != BP_CTR_ST) begin
        ctrNext_o = bpCtr_e'(ctr_i + 2'd1);
      end
    end else begin
      if (ctr_i != BP_CTR_SNT) begin
        ctrNext_o = bpCtr_e'(ctr_i - 2'd1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: a direct-mapped table of 2-bit counters plus
// a branch target buffer, read combinationally in IF and trained from the
// resolved outcome in EX. A wrong prediction produces a one-cycle registered
// redirect that the pipeline uses to flush IF/ID.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int INDEX_W = $clog2(ENTRIES)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fetchPc_i,
  output logic        predTaken_o,
  output logic [31:0] predPc_o,
  input  logic        updValid_i,
  input  logic        updIsJump_i,
  input  logic [31:0] updPc_i,
  input  logic        updTaken_i,
  input  logic [31:0] updTarget_i,
  input  logic        updPredTaken_i,
  input  logic [31:0] updPredPc_i,
  output logic        mispredict_o,
  output logic [31:0] redirectPc_o,
  output logic [31:0] branchCount_o,
  output logic [31:0] missCount_o
);

  localparam int TAG_W = 32 - INDEX_W - 2;

  // Prediction table, kept as plain flop arrays so lookups are combinational.
  bpCtr_e             ctr_q    [ENTRIES];
  logic               valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic               mispredict_q;
  logic [31:0]        redirectPc_q;
  logic [31:0]        branchCount_q;
  logic [31:0]        missCount_q;

  logic [INDEX_W-1:0] fetchIdx;
  logic [TAG_W-1:0]   fetchTag;
  logic               fetchHit;
  logic [INDEX_W-1:0] updIdx;
  logic [TAG_W-1:0]   updTag;
  logic               miss;
  logic [31:0]        correctPc;
  bpCtr_e             ctrNext;

  assign fetchIdx = fetchPc_i[INDEX_W+1:2];
  assign fetchTag = fetchPc_i[31:INDEX_W+2];
  assign updIdx   = updPc_i[INDEX_W+1:2];
  assign updTag   = updPc_i[31:INDEX_W+2];

  // Lookup reads the current table contents; an update in the same cycle
  // only becomes visible after the edge.
  always_comb begin
    fetchHit    = valid_q[fetchIdx] && (tag_q[fetchIdx] == fetchTag);
    predTaken_o = fetchHit && ctr_q[fetchIdx][1];
    predPc_o    = predTaken_o ? target_q[fetchIdx] : fetchPc_i + 32'd4;
  end

  // A miss is a wrong direction, or a taken branch that went somewhere other
  // than the PC fetched after it.
  always_comb begin
    miss      = updValid_i &&
                ((updTaken_i != updPredTaken_i) ||
                 (updTaken_i && (updTarget_i != updPredPc_i)));
    correctPc = updTaken_i ? updTarget_i : updPc_i + 32'd4;
  end

  bp_sat_counter uSatCounter (
    .ctr_i     (ctr_q[updIdx]),
    .taken_i   (updTaken_i),
    .forceSt_i (updIsJump_i),
    .ctrNext_o (ctrNext)
  );

  // Table training: counters always train; the BTB is only written on taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]    <= BP_CTR_WNT;
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (updValid_i) begin
      ctr_q[updIdx] <= ctrNext;
      if (updTaken_i) begin
        valid_q[updIdx]  <= 1'b1;
        tag_q[updIdx]    <= updTag;
        target_q[updIdx] <= updTarget_i;
      end
    end
  end

  // Redirect pulse and saturating statistics counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mispredict_q  <= 1'b0;
      redirectPc_q  <= '0;
      branchCount_q <= '0;
      missCount_q   <= '0;
    end else begin
      mispredict_q <= miss;
      if (miss) begin
        redirectPc_q <= correctPc;
        if (missCount_q != '1) begin
          missCount_q <= missCount_q + 32'd1;
        end
      end
      if (updValid_i && (branchCount_q != '1)) begin
        branchCount_q <= branchCount_q + 32'd1;
      end
    end
  end

  assign mispredict_o  = mispredict_q;
  assign redirectPc_o  = redirectPc_q;
  assign branchCount_o = branchCount_q;
  assign missCount_o   = missCount_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (16 entries).
// Redirect and statistics expectations are queued when an update is driven
// and popped once the edge that registers them has passed.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] fetchPc;
  logic        predTaken;
  logic [31:0] predPc;
  logic        updValid;
  logic        updIsJump;
  logic [31:0] updPc;
  logic        updTaken;
  logic [31:0] updTarget;
  logic        updPredTaken;
  logic [31:0] updPredPc;
  logic        mispredict;
  logic [31:0] redirectPc;
  logic [31:0] branchCount;
  logic [31:0] missCount;

  typedef struct {
    logic        mis;
    logic [31:0] redir;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sbQ[$];

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state.
  logic [1:0]  mCtr    [16];
  logic        mValid  [16];
  logic [25:0] mTag    [16];
  logic [31:0] mTarget [16];
  logic [31:0] mRedir;
  logic [31:0] mBc;
  logic [31:0] mMc;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fetchPc_i      (fetchPc),
    .predTaken_o    (predTaken),
    .predPc_o       (predPc),
    .updValid_i     (updValid),
    .updIsJump_i    (updIsJump),
    .updPc_i        (updPc),
    .updTaken_i     (updTaken),
    .updTarget_i    (updTarget),
    .updPredTaken_i (updPredTaken),
    .updPredPc_i    (updPredPc),
    .mispredict_o   (mispredict),
    .redirectPc_o   (redirectPc),
    .branchCount_o  (branchCount),
    .missCount_o    (missCount)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mCtr[i]    = 2'b01;
      mValid[i]  = 1'b0;
      mTag[i]    = '0;
      mTarget[i] = '0;
    end
    mRedir = '0;
    mBc    = '0;
    mMc    = '0;
  endtask

  function automatic logic [32:0] modelLookup(input logic [31:0] pc);
    logic [3:0] idx;
    logic       t;
    idx = pc[5:2];
    t = mValid[idx] && (mTag[idx] == pc[31:6]) && mCtr[idx][1];
    return {t, t ? mTarget[idx] : pc + 32'd4};
  endfunction

  // Compare the combinational prediction for pc against the model.
  task automatic lookupCheck(input logic [31:0] pc);
    logic [32:0] e;
    fetchPc = pc;
    #1;
    e = modelLookup(pc);
    checkOutput("predTaken", {31'd0, predTaken}, {31'd0, e[32]});
    checkOutput("predPc", predPc, e[31:0]);
  endtask

  // Lookup against literal values taken straight from the intended behaviour.
  task automatic lookupLiteral(input logic [31:0] pc, input logic expT, input logic [31:0] expPc);
    fetchPc = pc;
    #1;
    checkOutput("predTakenLit", {31'd0, predTaken}, {31'd0, expT});
    checkOutput("predPcLit", predPc, expPc);
  endtask

  // Drive one EX-stage cycle, queue the expected registered results, then
  // compare them after the edge.
  task automatic applyStimulus(input logic v, input logic j, input logic [31:0] pc,
                               input logic tk, input logic [31:0] tgt,
                               input logic pt, input logic [31:0] ppc);
    exp_t e;
    exp_t got;
    logic miss;
    logic [3:0] idx;
    @(negedge clk);
    updValid = v; updIsJump = j; updPc = pc; updTaken = tk;
    updTarget = tgt; updPredTaken = pt; updPredPc = ppc;
    lookupCheck(fetchPc);
    miss = v && ((tk != pt) || (tk && (tgt != ppc)));
    if (miss) begin
      mRedir = tk ? tgt : pc + 32'd4;
      if (mMc != 32'hFFFF_FFFF) mMc = mMc + 1;
    end
    if (v) begin
      if (mBc != 32'hFFFF_FFFF) mBc = mBc + 1;
      idx = pc[5:2];
      if (j) mCtr[idx] = 2'b11;
      else if (tk) mCtr[idx] = (mCtr[idx] == 2'b11) ? 2'b11 : mCtr[idx] + 2'b01;
      else mCtr[idx] = (mCtr[idx] == 2'b00) ? 2'b00 : mCtr[idx] - 2'b01;
      if (tk) begin
        mValid[idx]  = 1'b1;
        mTag[idx]    = pc[31:6];
        mTarget[idx] = tgt;
      end
    end
    e.mis = miss; e.redir = mRedir; e.bc = mBc; e.mc = mMc;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    updValid = 1'b0;
    got = sbQ.pop_front();
    checkOutput("mispredict", {31'd0, mispredict}, {31'd0, got.mis});
    checkOutput("redirectPc", redirectPc, got.redir);
    checkOutput("branchCount", branchCount, got.bc);
    checkOutput("missCount", missCount, got.mc);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] rPc, rTgt, rPpc;
    logic        rTk, rPt, rJ;
    rst = 1'b1;
    fetchPc = 32'h40;
    updValid = 0; updIsJump = 0; updPc = 0; updTaken = 0;
    updTarget = 0; updPredTaken = 0; updPredPc = 0;
    modelReset();
    #1;
    checkOutput("rstMispredict", {31'd0, mispredict}, 32'd0);
    checkOutput("rstRedirect", redirectPc, 32'd0);
    checkOutput("rstBranchCount", branchCount, 32'd0);
    checkOutput("rstMissCount", missCount, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Post-reset prediction and quiet pipeline.
    lookupLiteral(32'h40, 1'b0, 32'h44);
    idle();
    idle();

    // Train 0x40 taken to 0x100, then it should hit.
    fetchPc = 32'h40;
    applyStimulus(1, 0, 32'h40, 1, 32'h100, 0, 32'h44);
    checkOutput("trainRedirLit", redirectPc, 32'h100);
    lookupLiteral(32'h40, 1'b1, 32'h100);
    checkOutput("trainMissLit", missCount, 32'd1);
    idle();

    // Hysteresis: one not-taken drops back to weakly not-taken.
    applyStimulus(1, 0, 32'h40, 0, 32'h0, 1, 32'h100);
    checkOutput("hystRedirLit", redirectPc, 32'h44);
    lookupLiteral(32'h40, 1'b0, 32'h44);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 32'h40, 0, 32'h0, 0, 32'h44);
    // From a saturated 00 one taken only reaches 01, still predicting fall-through.
    applyStimulus(1, 0, 32'h40, 1, 32'h100, 0, 32'h44);
    lookupLiteral(32'h40, 1'b0, 32'h44);

    // Alias: JAL at 0x80 shares index 0 and evicts the 0x40 entry.
    applyStimulus(1, 0, 32'h40, 1, 32'h100, 0, 32'h44);
    applyStimulus(1, 1, 32'h80, 1, 32'h200, 0, 32'h84);
    lookupLiteral(32'h40, 1'b0, 32'h44);
    lookupLiteral(32'h80, 1'b1, 32'h200);
    // Counter at 11 survives one not-taken.
    applyStimulus(1, 0, 32'h80, 0, 32'h0, 1, 32'h200);
    lookupLiteral(32'h80, 1'b1, 32'h200);
    // Not-taken with a tag mismatch trains the counter but leaves the BTB.
    applyStimulus(1, 0, 32'h40, 0, 32'h0, 0, 32'h44);
    lookupCheck(32'h80);

    // Target mismatch, then matching target with no redirect.
    applyStimulus(1, 0, 32'h104, 1, 32'h180, 1, 32'h100);
    checkOutput("tgtRedirLit", redirectPc, 32'h180);
    applyStimulus(1, 0, 32'h104, 1, 32'h100, 1, 32'h100);
    checkOutput("tgtNoMisLit", {31'd0, mispredict}, 32'd0);

    // Same-index lookup during update sees the old entry.
    fetchPc = 32'h104;
    applyStimulus(1, 0, 32'h104, 0, 32'h0, 1, 32'h100);
    lookupCheck(32'h104);

    // Random mix of branches and jumps across a few aliasing PCs.
    for (int i = 0; i < 40; i++) begin
      rPc  = {24'd0, $urandom_range(0, 63) << 2} & 32'h0000_00FC;
      rTgt = ($urandom_range(0, 255) << 2);
      rJ   = ($urandom_range(0, 5) == 0);
      rTk  = rJ ? 1'b1 : 1'($urandom_range(0, 1));
      rPt  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       rPpc = rPc + 32'd4;
        1:       rPpc = rTgt;
        default: rPpc = $urandom;
      endcase
      fetchPc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      applyStimulus(1'($urandom_range(0, 3) != 0), rJ, rPc, rTk, rTgt, rPt, rPpc);
    end

    // Force a miss so the redirect is live, then reset mid-update.
    applyStimulus(1, 0, 32'h40, 1, 32'h300, 0, 32'h44);
    @(negedge clk);
    updValid = 1; updIsJump = 0; updPc = 32'h40; updTaken = 1;
    updTarget = 32'h400; updPredTaken = 0; updPredPc = 32'h44;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncMispredict", {31'd0, mispredict}, 32'd0);
    checkOutput("asyncRedirect", redirectPc, 32'd0);
    checkOutput("asyncBranchCount", branchCount, 32'd0);
    checkOutput("asyncMissCount", missCount, 32'd0);
    modelReset();
    lookupLiteral(32'h40, 1'b0, 32'h44);
    @(negedge clk);
    updValid = 1'b0;
    rst = 1'b0;
    lookupLiteral(32'h40, 1'b0, 32'h44);
    lookupLiteral(32'hFFFF_FFFC, 1'b0, 32'h0);
    idle();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
